bean_tracker: RTL and testbench

- Writer side of the 1200-bit bean map that the VGA renderer reads.
- After reset or restart, fills the map from the wall layout: one bean in every non-wall 16x16 cell of the 40x30 grid.
- On each game tick, clears the bean under Pac-Man's sprite centre, updates score and remaining count, and flags level clear.
- Sits between the game-logic tick/position registers and the display.

---
 rtl/bean_tracker_pkg.sv | 28 ++
 rtl/bean_tracker.sv | 99 +++++++++
 tb/tb_bean_tracker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bean_tracker_pkg.sv
// bean_tracker_pkg: grid geometry, state encodings and the bean bit-index rule
// shared between the bean writer and the renderer's bean decoder.
package bean_tracker_pkg;

    localparam int GRID_COLS   = 40;
    localparam int GRID_ROWS   = 30;
    localparam int CELL_SHIFT  = 4;
    localparam int SPRITE_HALF = 16;
    localparam int BEAN_POINTS = 10;
    localparam int CELLS       = GRID_COLS * GRID_ROWS;

    localparam logic [5:0]  LAST_COL = 6'(GRID_COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(GRID_ROWS - 1);
    localparam logic [10:0] COLS_W   = 11'(GRID_COLS);
    localparam logic [9:0]  ROWS_W   = 10'(GRID_ROWS);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PLAY = 2'd1,
        EAT  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [10:0] bean_idx(input logic [4:0] row, input logic [5:0] col);
        return 11'(32'(row) * GRID_COLS + 32'(col));
    endfunction

endpackage

// File: rtl/bean_tracker.sv
// bean_tracker: fills the bean map from the external wall lookup, then clears
// the bean under Pac-Man's sprite centre on each game tick.
module bean_tracker
    import bean_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 start,
    input  logic                 tick,
    input  logic                 over,
    input  logic [9:0]           PacX,
    input  logic [8:0]           PacY,
    output logic [9:0]           query_x,
    output logic [8:0]           query_y,
    input  logic                 query_is_wall,
    output logic [CELLS-1:0]     beanmap,
    output logic [13:0]          score,
    output logic [10:0]          bean_count,
    output logic                 ready,
    output logic                 all_eaten,
    output logic                 eat_pulse
);

    state_t      state;
    logic [5:0]  col;
    logic [4:0]  row;
    logic [10:0] idx;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        last_cell;
    logic        in_grid;

    // Cell centre is col*16+8: the low nibble is a constant 8.
    assign query_x   = {col, 4'd8};
    assign query_y   = {row, 4'd8};
    assign cx        = (11'(PacX) + 11'(SPRITE_HALF)) >> CELL_SHIFT;
    assign cy        = (10'(PacY) + 10'(SPRITE_HALF)) >> CELL_SHIFT;
    assign in_grid   = (cx < COLS_W) && (cy < ROWS_W);
    assign last_cell = (col == LAST_COL) && (row == LAST_ROW);

    always_ff @(posedge clk) begin
        if (!clrn || start) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            idx        <= '0;
            beanmap    <= '0;
            score      <= '0;
            bean_count <= '0;
            ready      <= 1'b0;
            all_eaten  <= 1'b0;
            eat_pulse  <= 1'b0;
        end else begin
            eat_pulse <= 1'b0;
            case (state)
                FILL: begin
                    beanmap[bean_idx(row, col)] <= ~query_is_wall;
                    if (!query_is_wall)
                        bean_count <= bean_count + 11'd1;
                    col <= (col == LAST_COL) ? 6'd0 : col + 6'd1;
                    if (col == LAST_COL)
                        row <= row + 5'd1;
                    if (last_cell) begin
                        row <= '0;
                        // Count still excludes this cycle's cell, so fold it in.
                        if (bean_count == 11'd0 && query_is_wall) begin
                            state     <= DONE;
                            all_eaten <= 1'b1;
                        end else begin
                            state <= PLAY;
                            ready <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (tick && !over && in_grid) begin
                        idx   <= bean_idx(cy[4:0], cx[5:0]);
                        state <= EAT;
                    end
                end
                EAT: begin
                    state <= PLAY;
                    if (beanmap[idx]) begin
                        beanmap[idx] <= 1'b0;
                        score        <= score + 14'(BEAN_POINTS);
                        bean_count   <= bean_count - 11'd1;
                        eat_pulse    <= 1'b1;
                        if (bean_count == 11'd1) begin
                            state     <= DONE;
                            all_eaten <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bean_tracker.sv
// tb_bean_tracker: directed checks of fill, eat, boundaries, clear, restart
// and reset behaviour against a stub wall map.
module tb_bean_tracker;

    logic          clk = 1'b0;
    logic          clrn, start, tick, over;
    logic [9:0]    pac_x, query_x;
    logic [8:0]    pac_y, query_y;
    logic          query_is_wall;
    logic [1199:0] beanmap;
    logic [13:0]   score;
    logic [10:0]   bean_count;
    logic          ready, all_eaten, eat_pulse;
    logic [1:0]    mode;
    logic [5:0]    qcol;
    logic [4:0]    qrow;
    int            checks = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    // Stub wall lookup: 0 = border walls on col 0/row 0, 1 = one bean at (5,3), 2 = all walls.
    assign qcol = query_x[9:4];
    assign qrow = query_y[8:4];
    assign query_is_wall = (mode == 2'd0) ? (qcol == 6'd0 || qrow == 5'd0) :
                           (mode == 2'd1) ? !(qcol == 6'd5 && qrow == 5'd3) : 1'b1;

    bean_tracker dut (
        .clk(clk), .clrn(clrn), .start(start), .tick(tick), .over(over),
        .PacX(pac_x), .PacY(pac_y), .query_x(query_x), .query_y(query_y),
        .query_is_wall(query_is_wall), .beanmap(beanmap), .score(score),
        .bean_count(bean_count), .ready(ready), .all_eaten(all_eaten),
        .eat_pulse(eat_pulse)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic tick_no_eat(input int x, input int y, input int want_score, input int want_count);
        int pulses = 0;
        pac_x = 10'(x);
        pac_y = 9'(y);
        tick  = 1'b1;
        step(1);
        tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (eat_pulse) pulses++;
            step(1);
        end
        checks++; if (pulses != 0) $display("FAIL no_eat_pulse x=%0d y=%0d got %0d pulses want 0", x, y, pulses); else passed++;
        checks++; if (score !== 14'(want_score) || bean_count !== 11'(want_count))
            $display("FAIL no_eat_state x=%0d y=%0d got score=%0d count=%0d want %0d/%0d", x, y, score, bean_count, want_score, want_count);
        else passed++;
    endtask

    task automatic test_reset();
        clrn = 1'b0; start = 1'b0; tick = 1'b0; over = 1'b0;
        pac_x = '0; pac_y = '0; mode = 2'd0;
        step(2);
        checks++; if (beanmap !== '0) $display("FAIL reset_beanmap got nonzero want 0"); else passed++;
        checks++; if (score !== 14'd0 || bean_count !== 11'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", score, bean_count); else passed++;
        checks++; if ({ready, all_eaten, eat_pulse} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ready, all_eaten, eat_pulse}); else passed++;
    endtask

    task automatic test_fill();
        clrn = 1'b1;
        step(1199);
        checks++; if (ready !== 1'b0) $display("FAIL fill_early_ready got %b want 0", ready); else passed++;
        step(1);
        checks++; if (ready !== 1'b1 || all_eaten !== 1'b0) $display("FAIL fill_ready got %b/%b want 1/0", ready, all_eaten); else passed++;
        checks++; if (bean_count !== 11'd1131) $display("FAIL fill_count got %0d want 1131", bean_count); else passed++;
        checks++; if (beanmap[0] !== 1'b0 || beanmap[41] !== 1'b1 || beanmap[1199] !== 1'b1 || beanmap[40] !== 1'b0)
            $display("FAIL fill_bits got b0=%b b41=%b b1199=%b b40=%b want 0/1/1/0", beanmap[0], beanmap[41], beanmap[1199], beanmap[40]);
        else passed++;
        checks++; if (score !== 14'd0) $display("FAIL fill_score got %0d want 0", score); else passed++;
    endtask

    task automatic test_eat();
        pac_x = 10'd24; pac_y = 9'd24; tick = 1'b1;
        step(1);
        tick = 1'b0;
        checks++; if (beanmap[82] !== 1'b1 || eat_pulse !== 1'b0) $display("FAIL eat_latency got bit=%b pulse=%b want 1/0", beanmap[82], eat_pulse); else passed++;
        step(1);
        checks++; if (beanmap[82] !== 1'b0) $display("FAIL eat_bit got %b want 0", beanmap[82]); else passed++;
        checks++; if (score !== 14'd10 || bean_count !== 11'd1130) $display("FAIL eat_counts got %0d/%0d want 10/1130", score, bean_count); else passed++;
        checks++; if (eat_pulse !== 1'b1) $display("FAIL eat_pulse_high got %b want 1", eat_pulse); else passed++;
        step(1);
        checks++; if (eat_pulse !== 1'b0) $display("FAIL eat_pulse_low got %b want 0", eat_pulse); else passed++;
    endtask

    task automatic test_boundary();
        tick_no_eat(24, 24, 10, 1130);
        tick_no_eat(630, 24, 10, 1130);
        tick_no_eat(24, 464, 10, 1130);
        pac_x = 10'd623; pac_y = 9'd24; tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
        checks++; if (beanmap[119] !== 1'b0 || score !== 14'd20 || bean_count !== 11'd1129)
            $display("FAIL edge_col39 got bit=%b score=%0d count=%0d want 0/20/1129", beanmap[119], score, bean_count);
        else passed++;
        step(1);
    endtask

    task automatic test_over();
        over = 1'b1;
        tick_no_eat(40, 24, 20, 1129);
        checks++; if (beanmap[83] !== 1'b1) $display("FAIL over_bit got %b want 1", beanmap[83]); else passed++;
        over = 1'b0;
    endtask

    task automatic test_clear();
        mode = 2'd1;
        pulse_start();
        checks++; if (score !== 14'd0 || bean_count !== 11'd0 || ready !== 1'b0 || beanmap !== '0)
            $display("FAIL start_clear got score=%0d count=%0d ready=%b", score, bean_count, ready);
        else passed++;
        step(1200);
        checks++; if (ready !== 1'b1 || bean_count !== 11'd1 || beanmap[125] !== 1'b1)
            $display("FAIL single_fill got ready=%b count=%0d bit=%b want 1/1/1", ready, bean_count, beanmap[125]);
        else passed++;
        pac_x = 10'd72; pac_y = 9'd40; tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
        checks++; if (beanmap[125] !== 1'b0 || bean_count !== 11'd0 || score !== 14'd10)
            $display("FAIL clear_state got bit=%b count=%0d score=%0d want 0/0/10", beanmap[125], bean_count, score);
        else passed++;
        checks++; if (all_eaten !== 1'b1 || eat_pulse !== 1'b1) $display("FAIL clear_flags got %b/%b want 1/1", all_eaten, eat_pulse); else passed++;
        step(1);
        tick_no_eat(72, 40, 10, 0);
        checks++; if (all_eaten !== 1'b1) $display("FAIL done_hold got %b want 1", all_eaten); else passed++;
    endtask

    task automatic test_restart();
        start = 1'b1; tick = 1'b1; pac_x = 10'd72; pac_y = 9'd40;
        step(1);
        start = 1'b0; tick = 1'b0;
        checks++; if (score !== 14'd0 || all_eaten !== 1'b0 || ready !== 1'b0 || bean_count !== 11'd0)
            $display("FAIL restart_clear got score=%0d ae=%b ready=%b count=%0d", score, all_eaten, ready, bean_count);
        else passed++;
        step(1200);
        checks++; if (ready !== 1'b1 || bean_count !== 11'd1) $display("FAIL restart_fill got ready=%b count=%0d want 1/1", ready, bean_count); else passed++;
    endtask

    task automatic test_empty();
        mode = 2'd2;
        pulse_start();
        step(1200);
        checks++; if (all_eaten !== 1'b1 || ready !== 1'b0 || bean_count !== 11'd0)
            $display("FAIL empty_fill got ae=%b ready=%b count=%0d want 1/0/0", all_eaten, ready, bean_count);
        else passed++;
    endtask

    task automatic test_reset_mid_fill();
        mode = 2'd0;
        pulse_start();
        step(600);
        checks++; if (bean_count !== 11'd546 || ready !== 1'b0) $display("FAIL mid_fill got count=%0d ready=%b want 546/0", bean_count, ready); else passed++;
        clrn = 1'b0;
        step(1);
        checks++; if (beanmap !== '0 || bean_count !== 11'd0 || score !== 14'd0 || {ready, all_eaten, eat_pulse} !== 3'b000)
            $display("FAIL mid_reset got count=%0d flags=%b want 0/000", bean_count, {ready, all_eaten, eat_pulse});
        else passed++;
        clrn = 1'b1;
        step(1200);
        checks++; if (ready !== 1'b1 || bean_count !== 11'd1131 || beanmap[41] !== 1'b1)
            $display("FAIL refill got ready=%b count=%0d want 1/1131", ready, bean_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_eat();
        test_boundary();
        test_over();
        test_clear();
        test_restart();
        test_empty();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
